inst_fetch_responder: RTL and testbench
=======================================

Name: inst_fetch_responder

Overview:
- Memory-side responder for the instruction fetcher's fetch handshake. Accepts a PC request and returns one 32-bit instruction word that may start on a 2-byte boundary (RVC).
- Backed by a direct-mapped word cache, refilled over the byte-wide RAM port through a grant-arbitrated fill FSM.
- Sits between the fetch unit and the memory arbiter, which it shares with the load/store path.

Parameters:
- IDX_W, 6, cache index width; 2^IDX_W 32-bit word entries.
- ADDR_W, 18, number of significant address bits; tag = pc[ADDR_W-1:IDX_W+2].

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global enable; when low, all state and outputs hold
- _clear  in  1  pipeline flush; aborts any request in progress
- _need_inst  in  1  fetcher request valid
- _pc_in  in  32  fetch address; bit0 is always 0
- _inst_ready_out  out  1  one-cycle response pulse
- _inst_out  out  32  instruction; for RVC, bits[15:0] hold the instruction and bits[31:16] are don't-care
- _mem_req  out  1  requests the RAM port
- _mem_grant  in  1  arbiter grant, valid in the same cycle as the request
- _mem_addr  out  32  byte address driven to RAM
- _mem_din  in  8  RAM read data, returned one cycle after the address was granted

Behaviour:
- Reset (async): state IDLE; all valid bits 0; _inst_ready_out=0; _inst_out=0; _mem_req=0; _mem_addr=0.
- rdy_in=0: no state, counter or array update; outputs hold their values.

IDLE state:
- Accept a request when _need_inst=1 and _clear=0.
- Latch pc, go to CHECK.
- _inst_ready_out is 0 in every cycle except the pulse cycle.

CHECK state:
- Read entry w0=pc[IDX_W+1:2].
- If pc[1]=1, the low halfword is w0[31:16]. The instruction is compressed iff that halfword [1:0]!=2'b11; otherwise the second word w1=w0+1 is also required, with its own tag check.
- All required words hit: register _inst_ready_out=1 and _inst_out at the next edge, return to IDLE.
  - Aligned word: _inst_out = w0.
  - Spanning: _inst_out = {w1[15:0], w0[31:16]}.
  - Compressed at pc[1]=1: _inst_out = {16'b0, w0[31:16]}.
- Hit latency: request accepted at edge T, pulse visible in the cycle after edge T+2.
- Any miss: go to FILL for the first missing word (w0 before w1).

FILL state:
- Hold _mem_req=1. Fetch 4 bytes of the target word, little-endian, into a shift register.
- Issue counter 0..3 advances only on a cycle with _mem_grant=1; _mem_addr = word_base + issue_cnt.
- A receive counter captures _mem_din exactly one cycle after each granted issue, regardless of grant in that later cycle.
- After the 4th byte is received: write data, tag and valid=1 into the entry, drop _mem_req, go to CHECK.
- Losing grant mid-fill only stalls issue; it never re-issues bytes already issued.

Wrap and boundaries:
- w0 at the highest index: w1 wraps to index 0 and uses the tag of pc+4.
- The pc+4 carry propagates into the tag.

_clear:
- In any state, go to IDLE at the next edge and drop _mem_req.
- A partially filled word is discarded and its valid bit is untouched.
- No pulse is produced for the aborted request; a pulse already registered is suppressed.
- A request is not accepted in the same cycle as _clear.

Other rules:
- No back-to-back accept: the next request is accepted at the earliest in the cycle after the pulse.
- Cache contents persist across _clear and are invalidated only by reset. Self-modifying code is not supported.

Test Plan:
- Cold miss: reset, pc=0x0, RAM[0..3]=13 05 00 00, grant always 1 -> _mem_addr steps 0,1,2,3; one pulse with _inst_out=0x00000513; _mem_req low afterwards.
- Hit: repeat pc=0x0 -> no _mem_req; pulse exactly 2 edges after accept with 0x00000513.
- RVC spanning: RAM[0x4..0xB]=01 45 93 05 10 00 00 00, pc=0x6 -> low half 0x0593 is not compressed; both words are filled; _inst_out=0x00100593. Then pc=0x4 -> hit, compressed, low half=0x4501.
- Grant stall: during a fill, drop _mem_grant for 3 cycles after the 2nd issue -> no duplicate addresses; data is correct; pulse is delayed by 3 cycles.
- Clear mid-fill: assert _clear after 2 bytes -> IDLE next edge, no pulse; the same pc re-requested refetches all 4 bytes.
- Async reset mid-fill: assert rst_in between edges -> outputs zero immediately; the next request to a previously cached pc misses.

Source files
------------

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder
//   Memory-side responder for the instruction fetcher. It takes one PC request
//   and returns one 32-bit instruction word. The word may start on a 2-byte
//   boundary (RVC). A direct-mapped word cache backs it, and that cache is
//   refilled a byte at a time over the shared RAM port.
//
// Ports
//   clk_in           system clock
//   rst_in           asynchronous, active-high reset
//   rdy_in           global enable; when low, all state and outputs hold
//   _clear           pipeline flush; aborts the request in flight
//   _need_inst       fetcher request valid
//   _pc_in           fetch address (bit0 always 0)
//   _inst_ready_out  one-cycle response pulse
//   _inst_out        instruction; for a compressed instruction only [15:0] matter
//   _mem_req         RAM port request
//   _mem_grant       arbiter grant, valid in the same cycle as the request
//   _mem_addr        byte address to RAM
//   _mem_din         RAM read data, one cycle after a granted address
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a fetch request
// S_READ  | cache entries for w0/w1 read and tag-compared into registers
// S_CHECK | decide hit (register pulse) or start a fill of the first missing word
// S_FILL  | fetching 4 bytes of the target word over the RAM port
module inst_fetch_responder #(
    parameter int IDX_W  = 6,
    parameter int ADDR_W = 18
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _need_inst,
    input  logic [31:0] _pc_in,
    output logic        _inst_ready_out,
    output logic [31:0] _inst_out,
    output logic        _mem_req,
    input  logic        _mem_grant,
    output logic [31:0] _mem_addr,
    input  logic [7:0]  _mem_din
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CHECK = 2'd2,
        S_FILL  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // bit0 of the PC is always zero, so it is never stored
    logic [31:1]      pc_q;
    logic             unused_pc0;

    logic [31:0]      data_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [31:0]      rd_w0_q, rd_w1_q;
    logic             hit0_q, hit1_q;

    logic             fill_sel_q;     // 0: filling w0, 1: filling w1
    logic [2:0]       issue_cnt_q;    // bit2 set once all four bytes are issued
    logic [1:0]       recv_cnt_q;
    logic             pend_q;         // a granted byte returns this cycle
    logic [23:0]      shreg_q;        // first three received bytes, byte0 lowest

    logic             ready_q;
    logic [31:0]      inst_q;

    logic [29:0]      pcw_next;
    logic [IDX_W-1:0] idx0, idx1, fill_idx;
    logic [TAG_W-1:0] tag0, tag1, fill_tag;
    logic [29:0]      fill_word;
    logic             issuing, granted, last_byte;
    logic [15:0]      half0;
    logic             need_w1, check_hit;
    logic [31:0]      check_inst;

    assign unused_pc0 = _pc_in[0];

    // Word-granular address arithmetic. The +1 carry ripples into the tag,
    // and the index wraps from the top entry to entry 0.
    assign pcw_next  = pc_q[31:2] + 30'd1;
    assign idx0      = pc_q[IDX_W+1:2];
    assign tag0      = pc_q[ADDR_W-1:IDX_W+2];
    assign idx1      = pcw_next[IDX_W-1:0];
    assign tag1      = pcw_next[ADDR_W-3:IDX_W];

    assign fill_word = fill_sel_q ? pcw_next : pc_q[31:2];
    assign fill_idx  = fill_word[IDX_W-1:0];
    assign fill_tag  = fill_word[ADDR_W-3:IDX_W];

    // The request is dropped once all four bytes are issued. A grant in the
    // wait cycle for the last byte would otherwise re-read memory.
    assign issuing   = (state_q == S_FILL) && !issue_cnt_q[2];
    assign granted   = issuing && _mem_grant;
    assign last_byte = (state_q == S_FILL) && pend_q && (recv_cnt_q == 2'd3);

    assign half0     = pc_q[1] ? rd_w0_q[31:16] : rd_w0_q[15:0];
    assign need_w1   = pc_q[1] && (half0[1:0] == 2'b11);
    assign check_hit = hit0_q && (!need_w1 || hit1_q);

    always_comb begin
        check_inst = rd_w0_q;
        if (pc_q[1]) begin
            if (need_w1) check_inst = {rd_w1_q[15:0], rd_w0_q[31:16]};
            else         check_inst = {16'h0000, rd_w0_q[31:16]};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)      state_q <= S_IDLE;
        else if (rdy_in) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (_need_inst && !ready_q) state_d = S_READ;
            S_READ:  state_d = S_CHECK;
            S_CHECK: state_d = check_hit ? S_IDLE : S_FILL;
            S_FILL:  if (last_byte) state_d = S_READ;
            default: state_d = S_IDLE;
        endcase
        if (_clear) state_d = S_IDLE;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_q        <= '0;
            valid_q     <= '0;
            rd_w0_q     <= '0;
            rd_w1_q     <= '0;
            hit0_q      <= 1'b0;
            hit1_q      <= 1'b0;
            fill_sel_q  <= 1'b0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            pend_q      <= 1'b0;
            shreg_q     <= '0;
            ready_q     <= 1'b0;
            inst_q      <= '0;
        end else if (rdy_in) begin
            ready_q <= 1'b0;
            pend_q  <= 1'b0;
            if (!_clear) begin
                case (state_q)
                    S_IDLE: begin
                        if (_need_inst && !ready_q) pc_q <= _pc_in[31:1];
                    end
                    S_READ: begin
                        rd_w0_q <= data_mem[idx0];
                        rd_w1_q <= data_mem[idx1];
                        hit0_q  <= valid_q[idx0] && (tag_mem[idx0] == tag0);
                        hit1_q  <= valid_q[idx1] && (tag_mem[idx1] == tag1);
                    end
                    S_CHECK: begin
                        if (check_hit) begin
                            ready_q <= 1'b1;
                            inst_q  <= check_inst;
                        end else begin
                            // w0 is filled first. If w0 already hits, w1 is the miss.
                            fill_sel_q  <= hit0_q;
                            issue_cnt_q <= '0;
                            recv_cnt_q  <= '0;
                        end
                    end
                    S_FILL: begin
                        if (granted) issue_cnt_q <= issue_cnt_q + 3'd1;
                        pend_q <= granted;
                        if (pend_q) begin
                            shreg_q    <= {_mem_din, shreg_q[23:8]};
                            recv_cnt_q <= recv_cnt_q + 2'd1;
                        end
                        if (last_byte) valid_q[fill_idx] <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Array data and tags need no reset because the valid bits gate every hit.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !_clear && last_byte) begin
            data_mem[fill_idx] <= {_mem_din, shreg_q};
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

    // A flush in the pulse cycle hides the response from the fetcher.
    assign _inst_ready_out = ready_q && !_clear;
    assign _inst_out       = inst_q;
    assign _mem_req        = issuing;
    assign _mem_addr       = issuing ? {fill_word, issue_cnt_q[1:0]} : 32'h0;

endmodule

// File: tb/tb_inst_fetch_responder.sv
module tb_inst_fetch_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _need_inst;
    logic [31:0] _pc_in;
    logic        _inst_ready_out;
    logic [31:0] _inst_out;
    logic        _mem_req;
    logic        _mem_grant;
    logic [31:0] _mem_addr;
    logic [7:0]  _mem_din;

    inst_fetch_responder #(.IDX_W(6), .ADDR_W(18)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        ._clear         (_clear),
        ._need_inst     (_need_inst),
        ._pc_in         (_pc_in),
        ._inst_ready_out(_inst_ready_out),
        ._inst_out      (_inst_out),
        ._mem_req       (_mem_req),
        ._mem_grant     (_mem_grant),
        ._mem_addr      (_mem_addr),
        ._mem_din       (_mem_din)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0]  ram [1024];
    logic [31:0] sb_q[$];
    logic [31:0] addr_log[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          pulse_cnt = 0;
    int          pulse_cyc = 0;
    int          fill_issues = 0;
    int          stall_cnt = 0;
    bit          stall_arm = 0;
    bit          pend_rd = 0;
    logic [31:0] pend_addr = '0;
    int          lat, lat_miss, p0, s0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        logic [9:0]  a;
        logic [15:0] lo;
        a  = pc[9:0];
        lo = {ram[a + 10'd1], ram[a]};
        if (!pc[1]) return {ram[a + 10'd3], ram[a + 10'd2], lo};
        if (lo[1:0] != 2'b11) return {16'h0000, lo};
        return {ram[a + 10'd3], ram[a + 10'd2], lo};
    endfunction

    // RAM model: a grant seen in a cycle returns its byte just after the next edge
    always @(posedge clk_in) begin
        cyc++;
        #1;
        if (pend_rd) _mem_din = ram[pend_addr[9:0]];
    end

    always @(negedge clk_in) begin
        if (stall_cnt > 0) begin
            stall_cnt--;
            if (stall_cnt == 0) _mem_grant = 1'b1;
        end else if (stall_arm && fill_issues == 2) begin
            _mem_grant = 1'b0;
            stall_cnt  = 3;
            stall_arm  = 0;
        end
        if (!rst_in && rdy_in && _mem_req && _mem_grant) begin
            addr_log.push_back(_mem_addr);
            pend_rd   = 1;
            pend_addr = _mem_addr;
            fill_issues++;
        end else begin
            pend_rd = 0;
        end
        if (!rst_in && _inst_ready_out) begin
            pulse_cnt++;
            pulse_cyc = cyc;
            if (sb_q.size() == 0) chk("pulse_unexpected", 32'(sb_q.size()), 32'd1);
            else chk("inst", _inst_out, sb_q.pop_front());
        end
    end

    // Drives one request. It expects nfill words to be fetched starting at
    // base b0 (then b1). It returns the accept-to-pulse latency in edges.
    task automatic fetch(input logic [31:0] pc, input int nfill, input logic [31:0] b0,
                         input logic [31:0] b1, input int rdy_hold, output int l);
        int t_acc, pc0, st;
        logic [31:0] ea;
        @(negedge clk_in);
        _pc_in = pc;
        _need_inst = 1'b1;
        sb_q.push_back(exp_inst(pc));
        st  = addr_log.size();
        pc0 = pulse_cnt;
        @(posedge clk_in);
        #1;
        t_acc = cyc;
        _need_inst = 1'b0;
        if (rdy_hold > 0) begin
            rdy_in = 1'b0;
            repeat (rdy_hold) @(posedge clk_in);
            #1 rdy_in = 1'b1;
        end
        for (int i = 0; i < 300 && pulse_cnt == pc0; i++) begin
            @(negedge clk_in);
            #1;
        end
        l = -1;
        if (pulse_cnt == pc0) chk("timeout", 32'(pulse_cnt), 32'(pc0 + 1));
        else l = pulse_cyc - t_acc;
        chk("fill_count", 32'(addr_log.size() - st), 32'(nfill * 4));
        for (int i = 0; i < nfill * 4 && st + i < addr_log.size(); i++) begin
            ea = ((i < 4) ? b0 : b1) + 32'(i % 4);
            chk("mem_addr", addr_log[st + i], ea);
        end
    endtask

    // Issue a request that is expected to be aborted; no scoreboard entry
    task automatic start_miss(input logic [31:0] pc, input int bytes);
        @(negedge clk_in);
        _pc_in = pc;
        _need_inst = 1'b1;
        s0 = addr_log.size();
        p0 = pulse_cnt;
        @(posedge clk_in);
        #1 _need_inst = 1'b0;
        for (int i = 0; i < 100 && addr_log.size() < s0 + bytes; i++) @(posedge clk_in);
        chk("issue_wait", 32'(addr_log.size() >= s0 + bytes), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        {ram[3], ram[2], ram[1], ram[0]}         = 32'h0000_0513;
        {ram[11], ram[10], ram[9], ram[8], ram[7], ram[6], ram[5], ram[4]} = 64'h0000_0010_0593_4501;
        {ram[19], ram[18], ram[17], ram[16]}     = 32'h00a0_0093;
        {ram[35], ram[34], ram[33], ram[32]}     = 32'hdead_beef;
        {ram[255], ram[254], ram[253], ram[252]} = 32'h1237_0000;
        {ram[259], ram[258], ram[257], ram[256]} = 32'h0000_5634;

        rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0; _need_inst = 1'b0;
        _pc_in = '0; _mem_grant = 1'b1; _mem_din = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_ready", 32'(_inst_ready_out), 32'd0);
        chk("rst_inst", _inst_out, 32'h0);
        chk("rst_req", 32'(_mem_req), 32'd0);
        chk("rst_addr", _mem_addr, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // cold miss, then hit
        fetch(32'h0, 1, 32'h0, 32'h0, 0, lat_miss);
        chk("cold_inst_const", exp_inst(32'h0), 32'h0000_0513);
        chk("req_after_fill", 32'(_mem_req), 32'd0);
        fetch(32'h0, 0, 32'h0, 32'h0, 0, lat);
        chk("hit_lat", 32'(lat), 32'd2);

        // spanning RVC, then compressed hit at the aligned half
        fetch(32'h6, 2, 32'h4, 32'h8, 0, lat);
        chk("span_inst_const", exp_inst(32'h6), 32'h0010_0593);
        fetch(32'h4, 0, 32'h0, 32'h0, 0, lat);
        chk("hit4_lat", 32'(lat), 32'd2);

        // global enable stalls a hit by three cycles
        fetch(32'h0, 0, 32'h0, 32'h0, 3, lat);
        chk("rdy_stall_lat", 32'(lat), 32'd5);

        // grant removed for 3 cycles after the second issue
        fill_issues = 0;
        stall_arm = 1;
        fetch(32'h10, 1, 32'h10, 32'h0, 0, lat);
        chk("grant_stall_lat", 32'(lat), 32'(lat_miss + 3));

        // top index wraps to index 0 with tag carry; evicts pc=0
        fetch(32'hFE, 2, 32'hFC, 32'h100, 0, lat);
        chk("wrap_inst_const", exp_inst(32'hFE), 32'h5634_1237);
        fetch(32'h0, 1, 32'h0, 32'h0, 0, lat);

        // clear mid-fill
        start_miss(32'h20, 2);
        @(negedge clk_in);
        _clear = 1'b1;
        @(posedge clk_in);
        #1 _clear = 1'b0;
        chk("clear_req", 32'(_mem_req), 32'd0);
        repeat (20) @(posedge clk_in);
        chk("clear_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        fetch(32'h20, 1, 32'h20, 32'h0, 0, lat);

        // async reset mid-fill
        start_miss(32'h30, 2);
        @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        chk("arst_req", 32'(_mem_req), 32'd0);
        chk("arst_addr", _mem_addr, 32'h0);
        chk("arst_inst", _inst_out, 32'h0);
        chk("arst_ready", 32'(_inst_ready_out), 32'd0);
        @(negedge clk_in);
        pend_rd = 0;
        rst_in = 1'b0;
        fetch(32'h0, 1, 32'h0, 32'h0, 0, lat);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
